// File: rtl/imem_loader.sv
// imem_loader: streams program words into instruction-memory cells, MS cell first
module imem_loader #(
   parameter int WORD_LEN       = 16,
   parameter int MEM_CELL_SIZE  = 4,
   parameter int INSTR_MEM_SIZE = 64,
   parameter int CPW            = WORD_LEN / MEM_CELL_SIZE,
   parameter int AW             = $clog2(INSTR_MEM_SIZE),
   parameter int CW             = $clog2(INSTR_MEM_SIZE / CPW) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [AW-1:0]            base_addr,
   input  logic [CW-1:0]            word_count,
   input  logic                     in_valid,
   input  logic [WORD_LEN-1:0]      in_word,
   output logic                     in_ready,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_waddr,
   output logic [MEM_CELL_SIZE-1:0] mem_wdata,
   output logic                     busy,
   output logic                     cpu_hold,
   output logic                     done
);
   localparam int BW = (CPW > 1) ? $clog2(CPW) : 1;
   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
   state_t                     state_q, state_d;
   logic [AW-1:0]              ptr_q, ptr_d, waddr_q, waddr_d;
   logic [CW-1:0]              rem_q, rem_d;
   logic [WORD_LEN-1:0]        sh_q, sh_d;
   logic [BW-1:0]              beat_q, beat_d;
   logic [MEM_CELL_SIZE-1:0]   wdata_q, wdata_d;
   logic                       we_q, we_d, done_q, done_d;
   assign in_ready  = (state_q == ACCEPT);
   assign busy      = (state_q != IDLE);
   assign cpu_hold  = busy;
   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   // Next state: the write-port registers always hold the beat being presented, so
   // the accept edge already launches beat 0 and the last beat edge launches nothing.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      beat_d  = beat_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            ptr_d   = base_addr;
            rem_d   = word_count;
            done_d  = (word_count == '0);
            state_d = done_d ? DONE : ACCEPT;
         end
         ACCEPT: if (in_valid) begin
            sh_d    = in_word << MEM_CELL_SIZE;
            wdata_d = in_word[WORD_LEN-1 -: MEM_CELL_SIZE];
            waddr_d = ptr_q;
            ptr_d   = ptr_q + 1'b1;
            beat_d  = '0;
            we_d    = 1'b1;
            state_d = WRITE;
         end
         WRITE: if (beat_q == BW'(CPW - 1)) begin
            rem_d   = rem_q - 1'b1;
            done_d  = (rem_q == CW'(1));
            state_d = done_d ? DONE : ACCEPT;
         end else begin
            sh_d    = sh_q << MEM_CELL_SIZE;
            wdata_d = sh_q[WORD_LEN-1 -: MEM_CELL_SIZE];
            waddr_d = ptr_q;
            ptr_d   = ptr_q + 1'b1;
            beat_d  = beat_q + 1'b1;
            we_d    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // State and registered outputs; reset abandons any load in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         sh_q    <= '0;
         beat_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         beat_q  <= beat_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-memory loader
module tb_imem_loader;
   logic        clk, rst, start, in_valid;
   logic [5:0]  base_addr;
   logic [4:0]  word_count;
   logic [15:0] in_word;
   logic        in_ready, mem_we, busy, cpu_hold, done;
   logic [5:0]  mem_waddr;
   logic [3:0]  mem_wdata;
   logic [3:0]  mem [64];
   int          wr_cnt, wr_base, errors, checks;
   logic [15:0] words [3];
   logic [15:0] wd;

   imem_loader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
      .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: captures every write the loader issues.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         mem[mem_waddr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input string tag, input logic [5:0] a, input logic [3:0] d);
      chk({tag, " we"}, 32'(mem_we), 32'd1);
      chk({tag, " addr"}, 32'(mem_waddr), 32'(a));
      chk({tag, " data"}, 32'(mem_wdata), 32'(d));
      chk({tag, " rdy"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      errors = 0; checks = 0; wr_cnt = 0;
      for (int i = 0; i < 64; i++) mem[i] = 4'h0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0; word_count = '0; in_word = '0;
      tick(); tick();
      chk("rst in_ready", 32'(in_ready), 0);
      chk("rst mem_we", 32'(mem_we), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst cpu_hold", 32'(cpu_hold), 0);
      chk("rst done", 32'(done), 0);
      chk("rst waddr", 32'(mem_waddr), 0);
      chk("rst wdata", 32'(mem_wdata), 0);
      rst = 1'b0;
      tick();

      // single word
      base_addr = 6'd8; word_count = 5'd1; in_word = 16'h370E; in_valid = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1 in_ready", 32'(in_ready), 1);
      chk("t1 cpu_hold", 32'(cpu_hold), 1);
      chk("t1 no write in accept", 32'(mem_we), 0);
      tick(); in_valid = 1'b0;
      wr("t1 b0", 6'd8, 4'h3); tick();
      wr("t1 b1", 6'd9, 4'h7); tick();
      wr("t1 b2", 6'd10, 4'h0); tick();
      wr("t1 b3", 6'd11, 4'hE); tick();
      chk("t1 done", 32'(done), 1);
      chk("t1 we off", 32'(mem_we), 0);
      chk("t1 busy in done", 32'(busy), 1);
      tick();
      chk("t1 done fall", 32'(done), 0);
      chk("t1 busy fall", 32'(busy), 0);
      chk("t1 hold fall", 32'(cpu_hold), 0);
      chk("t1 readback", 32'({mem[8], mem[9], mem[10], mem[11]}), 32'h370E);

      // back-to-back
      words[0] = 16'h3004; words[1] = 16'h0304; words[2] = 16'h0374;
      wr_base = wr_cnt;
      base_addr = 6'd12; word_count = 5'd3; in_valid = 1'b1; start = 1'b1; in_word = words[0];
      tick();
      start = 1'b0;
      for (int w = 0; w < 3; w++) begin
         in_word = words[w];
         chk("t2 ready", 32'(in_ready), 1);
         chk("t2 no accept write", 32'(mem_we), 0);
         tick();
         wd = words[w];
         for (int k = 0; k < 4; k++) begin
            wr("t2 beat", 6'(12 + 4 * w + k), wd[15 - 4 * k -: 4]);
            tick();
         end
      end
      in_valid = 1'b0;
      chk("t2 done", 32'(done), 1);
      tick();
      chk("t2 busy fall", 32'(busy), 0);
      chk("t2 write count", 32'(wr_cnt - wr_base), 12);
      chk("t2 readback w2", 32'({mem[20], mem[21], mem[22], mem[23]}), 32'h0374);

      // stall + wrap
      words[0] = 16'hA5C3; words[1] = 16'h1F2E;
      wr_base = wr_cnt;
      base_addr = 6'd60; word_count = 5'd2; in_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int w = 0; w < 2; w++) begin
         for (int s = 0; s < 3; s++) begin
            chk("t3 stall ready", 32'(in_ready), 1);
            chk("t3 stall no write", 32'(mem_we), 0);
            tick();
         end
         in_valid = 1'b1; in_word = words[w];
         tick();
         in_valid = 1'b0;
         wd = words[w];
         for (int k = 0; k < 4; k++) begin
            wr("t3 beat", 6'(60 + 4 * w + k), wd[15 - 4 * k -: 4]);
            tick();
         end
      end
      chk("t3 done", 32'(done), 1);
      tick();
      chk("t3 write count", 32'(wr_cnt - wr_base), 8);
      chk("t3 readback hi", 32'({mem[60], mem[61], mem[62], mem[63]}), 32'hA5C3);
      chk("t3 readback wrap", 32'({mem[0], mem[1], mem[2], mem[3]}), 32'h1F2E);

      // count = 0
      wr_base = wr_cnt;
      base_addr = 6'd50; word_count = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4 done", 32'(done), 1);
      chk("t4 busy", 32'(busy), 1);
      chk("t4 no ready", 32'(in_ready), 0);
      chk("t4 no we", 32'(mem_we), 0);
      tick();
      chk("t4 done fall", 32'(done), 0);
      chk("t4 idle", 32'(busy), 0);
      chk("t4 no writes", 32'(wr_cnt - wr_base), 0);

      // start ignored while writing
      base_addr = 6'd32; word_count = 5'd1; start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; in_word = 16'hBEEF;
      tick();
      in_valid = 1'b0;
      wr("t5 b0", 6'd32, 4'hB);
      base_addr = 6'd5; word_count = 5'd7; start = 1'b1;
      tick();
      start = 1'b0;
      wr("t5 b1", 6'd33, 4'hE); tick();
      wr("t5 b2", 6'd34, 4'hE); tick();
      wr("t5 b3", 6'd35, 4'hF); tick();
      chk("t5 done", 32'(done), 1);
      tick();
      chk("t5 idle", 32'(busy), 0);
      chk("t5 readback", 32'({mem[32], mem[33], mem[34], mem[35]}), 32'hBEEF);

      // reset mid-WRITE after two beats
      wr_base = wr_cnt;
      base_addr = 6'd40; word_count = 5'd2; start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1; in_word = 16'h1234;
      tick();
      in_valid = 1'b0;
      wr("t6 b0", 6'd40, 4'h1); tick();
      wr("t6 b1", 6'd41, 4'h2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6 we stop", 32'(mem_we), 0);
      chk("t6 idle", 32'(busy), 0);
      chk("t6 no ready", 32'(in_ready), 0);
      chk("t6 no done", 32'(done), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6 done quiet", 32'(done), 0);
         chk("t6 we quiet", 32'(mem_we), 0);
      end
      chk("t6 write count", 32'(wr_cnt - wr_base), 2);
      chk("t6 kept cells", 32'({mem[40], mem[41], mem[42], mem[43]}), 32'h1200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
